a2d_scan: RTL and testbench



---
 rtl/a2d_scan_pkg.sv | 27 ++
 rtl/a2d_result_rf.sv | 40 ++++
 rtl/a2d_scan.sv | 128 ++++++++++++
 tb/tb_a2d_scan.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/a2d_scan_pkg.sv
// Shared types and constants for the ADC channel scanner.
// Optional continuous scanning is enabled with macro A2D_SCAN_CONT_EN.
package a2d_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT_CMD,
    RD,
    WAIT_RD,
    STORE
  } state_t;

  localparam int CMD_CHNL_LSB = 11;
  localparam int CMD_W        = 16;
  localparam int MAX_CHNL     = 8;
  localparam int CHNL_W       = 3;

  // SPI command word addressing one ADC channel
  function automatic logic [CMD_W-1:0] chnl_cmd(input logic [CHNL_W-1:0] chnl);
    logic [CMD_W-1:0] word;
    word = '0;
    word[CMD_CHNL_LSB +: CHNL_W] = chnl;
    return word;
  endfunction

endpackage

// File: rtl/a2d_result_rf.sv
// Per-channel conversion result register file: one write port, one
// combinational read port; unused channel addresses read back as zero.
module a2d_result_rf
  import a2d_scan_pkg::*;
#(
  parameter int NUM_CHNL = 8,
  parameter int RES_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CHNL_W-1:0] wr_addr,
  input  logic [RES_W-1:0]  wr_data,
  input  logic [CHNL_W-1:0] rd_addr,
  output logic [RES_W-1:0]  rd_data
);

  logic [RES_W-1:0] mem_reg [NUM_CHNL];

  for (genvar gi = 0; gi < NUM_CHNL; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_reg[gi] <= '0;
      end else if (wr_en && (wr_addr == CHNL_W'(gi))) begin
        mem_reg[gi] <= wr_data;
      end
    end
  end

  // Address match loop keeps out-of-range selects at zero without indexing past the array
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CHNL; i++) begin
      if (rd_addr == CHNL_W'(i)) begin
        rd_data = mem_reg[i];
      end
    end
  end

endmodule

// File: rtl/a2d_scan.sv
// Scans ADC channels 0..NUM_CHNL-1 through a 16-bit SPI master, two
// transactions per channel. Macro A2D_SCAN_CONT_EN adds port cont for free-running scans.
module a2d_scan
  import a2d_scan_pkg::*;
#(
  parameter int NUM_CHNL = 8,
  parameter int RES_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
`ifdef A2D_SCAN_CONT_EN
  input  logic              cont,
`endif
  input  logic              strt_cnv,
  output logic              busy,
  output logic              cnv_cmplt,
  output logic              wrt,
  output logic [CMD_W-1:0]  cmd,
  input  logic              done,
  input  logic [15:0]       rd_data,
  input  logic [CHNL_W-1:0] rd_chnl,
  output logic [RES_W-1:0]  rd_result
);

  localparam logic [CHNL_W-1:0] LAST_CHNL = CHNL_W'(NUM_CHNL - 1);

  state_t            state_reg, state_next;
  logic [CHNL_W-1:0] chnl_reg, chnl_next;
  logic              cmplt_reg, cmplt_next;
  logic              done_dly_reg;
  logic [RES_W-1:0]  data_reg;
  logic              done_rise;
  logic              store_en;

  assign done_rise = done & ~done_dly_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      chnl_reg     <= '0;
      cmplt_reg    <= 1'b0;
      done_dly_reg <= 1'b0;
      data_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      chnl_reg     <= chnl_next;
      cmplt_reg    <= cmplt_next;
      done_dly_reg <= done;
      // Capture the read word at the edge so a master that updates rd_data early is harmless
      if ((state_reg == WAIT_RD) && done_rise) begin
        data_reg <= rd_data[RES_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    chnl_next  = chnl_reg;
    cmplt_next = cmplt_reg;
    store_en   = 1'b0;
    wrt        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (strt_cnv) begin
          cmplt_next = 1'b0;
          chnl_next  = '0;
          state_next = CMD;
        end
      end
      CMD: begin
        wrt        = 1'b1;
        cmplt_next = 1'b0;
        state_next = WAIT_CMD;
      end
      // The first transaction returns the previous conversion; its data is dropped
      WAIT_CMD: begin
        if (done_rise) begin
          state_next = RD;
        end
      end
      RD: begin
        wrt        = 1'b1;
        state_next = WAIT_RD;
      end
      WAIT_RD: begin
        if (done_rise) begin
          state_next = STORE;
        end
      end
      STORE: begin
        store_en = 1'b1;
        if (chnl_reg == LAST_CHNL) begin
          cmplt_next = 1'b1;
          chnl_next  = '0;
`ifdef A2D_SCAN_CONT_EN
          state_next = cont ? CMD : IDLE;
`else
          state_next = IDLE;
`endif
        end else begin
          chnl_next  = chnl_reg + 1'b1;
          state_next = CMD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign cnv_cmplt = cmplt_reg;
  assign cmd       = (state_reg == IDLE) ? '0 : chnl_cmd(chnl_reg);

  a2d_result_rf #(
    .NUM_CHNL (NUM_CHNL),
    .RES_W    (RES_W)
  ) u_result_rf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (store_en),
    .wr_addr (chnl_reg),
    .wr_data (data_reg),
    .rd_addr (rd_chnl),
    .rd_data (rd_result)
  );

endmodule

// File: tb/tb_a2d_scan.sv
// Directed bench: a 1-channel and an 8-channel scanner, each driven by a
// behavioural SPI master + ADC model that answers with the previous conversion.
module tb_a2d_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       strt [2];
  logic [2:0] rd_chnl [2];
`ifdef A2D_SCAN_CONT_EN
  logic       cont = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic        busy, cnv_cmplt, wrt, done;
    logic [15:0] cmd, rd_data;
    logic [11:0] rd_result;
    logic [11:0] held;
    logic [2:0]  cur_ch;
    logic [15:0] cmd_log [32];
    int          wrt_cnt;
    int          xfer_cnt;
    int          cnt;

    initial begin
      done     = 1'b0;
      rd_data  = 16'h0000;
      held     = 12'h000;
      cur_ch   = 3'd0;
      wrt_cnt  = 0;
      xfer_cnt = 0;
      cnt      = 0;
    end

    a2d_scan #(
      .NUM_CHNL ((gi == 0) ? 1 : 8),
      .RES_W    (12)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
`ifdef A2D_SCAN_CONT_EN
      .cont      (cont),
`endif
      .strt_cnv  (strt[gi]),
      .busy      (busy),
      .cnv_cmplt (cnv_cmplt),
      .wrt       (wrt),
      .cmd       (cmd),
      .done      (done),
      .rd_data   (rd_data),
      .rd_chnl   (rd_chnl[gi]),
      .rd_result (rd_result)
    );

    // SPI master + ADC: done held high for two cycles (edge detector must be used);
    // each transfer returns the conversion started by the previous one, with junk upper nibble.
    // Conversion of channel c at transfer n = 0xC00 - 0x100*c - 0x10*(n/2). Not reset by rst.
    always @(posedge clk) begin
      done <= (cnt == 3) || (cnt == 2);
      if (cnt == 3) begin
        rd_data  <= {4'hF, held};
        held     <= 12'hC00 - 12'h100 * 12'(cur_ch) - 12'h010 * 12'(xfer_cnt / 2);
        xfer_cnt <= xfer_cnt + 1;
      end
      if (wrt) begin
        if (wrt_cnt < 32) cmd_log[wrt_cnt] <= cmd;
        wrt_cnt <= wrt_cnt + 1;
        cur_ch  <= cmd[13:11];
        cnt     <= 6;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cmplt(input int inst, input int budget);
    int k;
    k = 0;
    while (k < budget && ((inst == 0) ? g_ch[0].cnv_cmplt : g_ch[1].cnv_cmplt) !== 1'b1) begin
      step();
      k++;
    end
    check("scan_timeout", {31'd0, (inst == 0) ? g_ch[0].cnv_cmplt : g_ch[1].cnv_cmplt}, 32'd1);
  endtask

  logic [11:0] exp8 [8];
  int          base_cnt;

  initial begin
    strt[0] = 1'b0; strt[1] = 1'b0;
    rd_chnl[0] = 3'd0; rd_chnl[1] = 3'd0;
    exp8[0] = 12'hC00; exp8[1] = 12'hAF0; exp8[2] = 12'h9E0; exp8[3] = 12'h8D0;
    exp8[4] = 12'h7C0; exp8[5] = 12'h6B0; exp8[6] = 12'h5A0; exp8[7] = 12'h490;

    // Held in reset for 50 cycles: nothing may start
    for (int i = 0; i < 50; i++) begin
      step();
      if (g_ch[0].wrt !== 1'b0 || g_ch[1].wrt !== 1'b0 || g_ch[0].busy !== 1'b0 || g_ch[1].busy !== 1'b0)
        check($sformatf("rst_idle_cyc%0d", i), {g_ch[0].wrt, g_ch[1].wrt, g_ch[0].busy, g_ch[1].busy}, 32'd0);
    end
    check("rst_wrt_cnt0", g_ch[0].wrt_cnt, 0);
    check("rst_wrt_cnt1", g_ch[1].wrt_cnt, 0);
    for (int c = 0; c < 8; c++) begin
      rd_chnl[0] = 3'(c); rd_chnl[1] = 3'(c);
      #1;
      check($sformatf("rst_result0_ch%0d", c), g_ch[0].rd_result, 0);
      check($sformatf("rst_result1_ch%0d", c), g_ch[1].rd_result, 0);
    end
    rst = 1'b0;
    step();
    check("idle_busy", g_ch[1].busy, 0);
    check("idle_cmplt", g_ch[1].cnv_cmplt, 0);
    check("idle_cmd", g_ch[1].cmd, 16'h0000);

    // Single-channel scans x3 on instance 0
    for (int s = 0; s < 3; s++) begin
      strt[0] = 1'b1;
      step();
      strt[0] = 1'b0;
      check($sformatf("s%0d_latency_wrt", s), g_ch[0].wrt, 1);
      check($sformatf("s%0d_busy", s), g_ch[0].busy, 1);
      check($sformatf("s%0d_cmplt_clr", s), g_ch[0].cnv_cmplt, 0);
      step();
      check($sformatf("s%0d_wrt_one_cycle", s), g_ch[0].wrt, 0);
      wait_cmplt(0, 100);
      check($sformatf("s%0d_busy_done", s), g_ch[0].busy, 0);
      check($sformatf("s%0d_wrt_cnt", s), g_ch[0].wrt_cnt, 2 * (s + 1));
      check($sformatf("s%0d_cmd_a", s), g_ch[0].cmd_log[2 * s], 16'h0000);
      check($sformatf("s%0d_cmd_b", s), g_ch[0].cmd_log[2 * s + 1], 16'h0000);
      rd_chnl[0] = 3'd0;
      #1;
      check($sformatf("s%0d_result", s), g_ch[0].rd_result, (s == 0) ? 12'hC00 : (s == 1) ? 12'hBF0 : 12'hBE0);
      rd_chnl[0] = 3'd1;
      #1;
      check($sformatf("s%0d_out_of_range", s), g_ch[0].rd_result, 0);
      step(3);
    end

    // Eight-channel scan with strt_cnv held high throughout
    strt[1] = 1'b1;
    step();
    check("s8_latency_wrt", g_ch[1].wrt, 1);
    wait_cmplt(1, 1000);
    strt[1] = 1'b0;
    check("s8_busy_done", g_ch[1].busy, 0);
    check("s8_wrt_cnt", g_ch[1].wrt_cnt, 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("s8_cmd%0d", k), g_ch[1].cmd_log[k], {2'b00, 3'(k / 2), 11'h000});
    for (int c = 0; c < 8; c++) begin
      rd_chnl[1] = 3'(c);
      #1;
      check($sformatf("s8_result_ch%0d", c), g_ch[1].rd_result, exp8[c]);
    end
    step(20);
    check("s8_no_extra_wrt", g_ch[1].wrt_cnt, 16);
    check("s8_cmplt_held", g_ch[1].cnv_cmplt, 1);

    // Reset while waiting for the channel-1 read; the late done must be ignored
    strt[1] = 1'b1;
    step();
    strt[1] = 1'b0;
    check("rr_cmplt_clr", g_ch[1].cnv_cmplt, 0);
    begin
      int k;
      k = 0;
      while (g_ch[1].wrt_cnt < 20 && k < 200) begin
        step();
        k++;
      end
      check("rr_reach_wait_rd", g_ch[1].wrt_cnt, 20);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rr_busy", g_ch[1].busy, 0);
    check("rr_wrt", g_ch[1].wrt, 0);
    check("rr_cmd", g_ch[1].cmd, 16'h0000);
    check("rr_cmplt", g_ch[1].cnv_cmplt, 0);
    rd_chnl[1] = 3'd0;
    #1;
    check("rr_result_clr", g_ch[1].rd_result, 0);
    base_cnt = g_ch[1].wrt_cnt;
    step(40);
    check("rr_no_wrt", g_ch[1].wrt_cnt, base_cnt);
    check("rr_still_idle", g_ch[1].busy, 0);
    strt[1] = 1'b1;
    step();
    strt[1] = 1'b0;
    check("rr_restart_wrt", g_ch[1].wrt, 1);
    check("rr_restart_cmd", g_ch[1].cmd, 16'h0000);
    wait_cmplt(1, 1000);
    check("rr_restart_cnt", g_ch[1].wrt_cnt, base_cnt + 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
